// File: rtl/piano_pkg.sv
// Shared definitions for the piano voice: note table, half-period helper and FSM states.
package piano_pkg;

  localparam int NOTE_HZ [0:7] = '{440, 494, 523, 587, 659, 698, 784, 880};

  function automatic int half_period(input int clk_hz, input int hz);
    return clk_hz / (2 * hz);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/piano_key_sel.sv
// Key bank synchronizer (two flops) followed by a lowest-index priority encoder.
module piano_key_sel #(
  parameter int NUM_KEYS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                any,
  output logic [IDX_W-1:0]    sel
);

  logic [NUM_KEYS-1:0] meta_q, meta_d;
  logic [NUM_KEYS-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = keys;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  // Scan downward so the lowest pressed index is the last one written.
  always_comb begin
    any = |sync_q;
    sel = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (sync_q[i]) sel = IDX_W'(i);
    end
  end

endmodule

// File: rtl/piano_voice.sv
// Single-voice square-wave generator; note changes land only on full-period boundaries.
// Optional octave shift input is enabled with PIANO_VOICE_OCTAVE_EN.
module piano_voice
  import piano_pkg::*;
#(
  parameter int   CLK_HZ   = 25000000,
  parameter int   NUM_KEYS = 8,
  parameter int   CNT_W    = 16,
  localparam int  IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
`ifdef PIANO_VOICE_OCTAVE_EN
  input  logic [1:0]          octave,
`endif
  output logic                speaker,
  output logic                active,
  output logic [IDX_W-1:0]    note_idx
);

  if (NUM_KEYS < 2 || NUM_KEYS > 8) begin : g_bad_keys
    $fatal(1, "piano_voice: NUM_KEYS must be within 2..8");
  end

  logic [CNT_W:0] half_tbl [NUM_KEYS];

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_half
    localparam int HALF = half_period(CLK_HZ, NOTE_HZ[i]);
    if (HALF < 2 || longint'(HALF) > (longint'(1) << CNT_W)) begin : g_bad_half
      $fatal(1, "piano_voice: half period out of range for key %0d", i);
    end
    assign half_tbl[i] = (CNT_W + 1)'(HALF);
  end

  logic             any;
  logic [IDX_W-1:0] sel;

  piano_key_sel #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_key_sel (
    .clk  (clk),
    .rst  (rst),
    .keys (keys),
    .any  (any),
    .sel  (sel)
  );

  logic [1:0] oct_s;

`ifdef PIANO_VOICE_OCTAVE_EN
  logic [1:0] oct_meta_q, oct_meta_d, oct_sync_q, oct_sync_d;

  always_comb begin
    oct_meta_d = octave;
    oct_sync_d = oct_meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oct_meta_q <= '0;
      oct_sync_q <= '0;
    end else begin
      oct_meta_q <= oct_meta_d;
      oct_sync_q <= oct_sync_d;
    end
  end

  assign oct_s = oct_sync_q;
`else
  assign oct_s = 2'd0;
`endif

  // Deep octave shifts of short notes can reach zero; clamp rather than wrap.
  logic [CNT_W:0]   shifted;
  logic [CNT_W-1:0] limit_new;

  always_comb begin
    shifted   = half_tbl[sel] >> oct_s;
    limit_new = (shifted == '0) ? '0 : CNT_W'(shifted - 1'b1);
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             spk_q, spk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      idx_q   <= '0;
      spk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      idx_q   <= idx_d;
      spk_q   <= spk_d;
    end
  end

  // A period is low half then high half; the falling edge is the only reload point.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    idx_d   = idx_q;
    spk_d   = spk_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        spk_d = 1'b0;
        if (any) begin
          limit_d = limit_new;
          idx_d   = sel;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (cnt_q == limit_q) begin
          cnt_d = '0;
          spk_d = ~spk_q;
          if (spk_q) begin
            if (!any) begin
              state_d = IDLE;
            end else begin
              limit_d = limit_new;
              idx_d   = sel;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign speaker  = spk_q;
  assign active   = (state_q == PLAY);
  assign note_idx = idx_q;

endmodule

// File: tb/tb_piano_voice.sv
// Scoreboard bench for piano_voice: predicted speaker/active events are queued and checked on arrival.
module tb_piano_voice;

  localparam int TB_CLK_HZ = 250000;
  localparam int W = 24;
  localparam logic [1:0] K_ACT_RISE = 2'd0;
  localparam logic [1:0] K_RISE     = 2'd1;
  localparam logic [1:0] K_FALL     = 2'd2;
  localparam logic [1:0] K_ACT_FALL = 2'd3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys = 8'h00;
  logic [1:0] octave = 2'd0;
  logic       speaker;
  logic       active;
  logic [2:0] note_idx;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  piano_voice #(
    .CLK_HZ   (TB_CLK_HZ),
    .NUM_KEYS (8),
    .CNT_W    (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .keys     (keys),
`ifdef PIANO_VOICE_OCTAVE_EN
    .octave   (octave),
`endif
    .speaker  (speaker),
    .active   (active),
    .note_idx (note_idx)
  );

  // ---------------- reference model ----------------
  int note_hz [8] = '{440, 494, 523, 587, 659, 698, 784, 880};

  function automatic int lowest(input logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return i;
    return 0;
  endfunction

  function automatic int oct_eff(input logic [1:0] o);
`ifdef PIANO_VOICE_OCTAVE_EN
    return int'(o);
`else
    return 0 * int'(o);
`endif
  endfunction

  function automatic int half_of(input int note, input logic [1:0] o);
    return (TB_CLK_HZ / (2 * note_hz[note])) >> oct_eff(o);
  endfunction

  function automatic logic [7:0] rand_keys(input logic [7:0] k);
    logic [7:0] lowbit, above, r;
    int m;
    m = int'($urandom_range(2, 0));
    if (m == 0) return k;
    if (m == 1) begin
      lowbit = k & (~k + 8'd1);
      above  = ~((lowbit << 1) - 8'd1);
      r      = 8'($urandom);
      return k | (r & above);
    end
    return 8'($urandom_range(255, 1));
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic [1:0] kind, input int note, input int len);
    exp_q.push_back({kind, 2'b00, 4'(note), 16'(len)});
  endtask

  task automatic check_evt(input logic [1:0] kind, input int len);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: kind %0d len %0d note %0d, nothing expected (cycle %0d)",
               kind, len, note_idx, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("evt_kind", kind, e[23:22]);
    check("evt_len", len, e[15:0]);
    check("evt_note", note_idx, e[19:16]);
  endtask

  // ---------------- monitor ----------------
  bit   mon_en   = 1'b0;
  int   apply_cyc = 0;
  int   last_evt = 0;
  logic prev_spk = 1'b0;
  logic prev_act = 1'b0;

  always @(negedge clk) begin
    if (!mon_en) begin
      last_evt = cyc;
    end else begin
      if (!prev_act && active) begin
        check_evt(K_ACT_RISE, cyc - apply_cyc);
        last_evt = cyc;
      end
      if (speaker != prev_spk) begin
        check_evt(speaker ? K_RISE : K_FALL, cyc - last_evt);
        last_evt = cyc;
      end
      if (prev_act && !active) begin
        check_evt(K_ACT_FALL, cyc - last_evt);
        last_evt = cyc;
      end
    end
    prev_spk = speaker;
    prev_act = active;
  end

  // ---------------- driver tasks ----------------
  // Keys were applied at apply_cyc; seq[s] is driven somewhere inside period s.
  task automatic run_periods(input logic [7:0] p, input logic [7:0] seq [4],
                             input logic [1:0] oseq [5], input int nsteps);
    int b, h, c, note;
    logic [1:0] oc;
    note = lowest(p);
    oc   = oseq[0];
    push(K_ACT_RISE, note, 3);
    b = apply_cyc + 3;
    for (int s = 0; s < nsteps; s++) begin
      h = half_of(note, oc);
      push(K_RISE, note, h);
      c = b + 1 + int'($urandom_range(2 * h - 5, 0));
      while (cyc < c) @(negedge clk);
      keys   = seq[s];
      octave = oseq[s+1];
      b = b + 2 * h;
      if (seq[s] == 8'h00) begin
        push(K_FALL, note, h);
        push(K_ACT_FALL, note, 0);
      end else begin
        note = lowest(seq[s]);
        push(K_FALL, note, h);
      end
      oc = oseq[s+1];
    end
    while (cyc < b + 1) @(negedge clk);
  endtask

  task automatic play(input logic [7:0] p, input logic [7:0] seq [4],
                      input logic [1:0] oseq [5], input int nsteps);
    @(negedge clk);
    keys      = p;
    octave    = oseq[0];
    apply_cyc = cyc;
    run_periods(p, seq, oseq, nsteps);
  endtask

  task automatic reset_test(input logic [7:0] p);
    int b, h, note;
    logic [7:0] seq [4];
    logic [1:0] oseq [5];
    seq  = '{p, 8'h00, 8'h00, 8'h00};
    oseq = '{default: 2'd0};
    @(negedge clk);
    keys      = p;
    octave    = 2'd0;
    apply_cyc = cyc;
    note = lowest(p);
    h    = half_of(note, 2'd0);
    push(K_ACT_RISE, note, 3);
    push(K_RISE, note, h);
    b = apply_cyc + 3;
    while (cyc < b + h + h / 2) @(negedge clk);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_speaker", speaker, 0);
    check("rst_mid_active", active, 0);
    check("rst_mid_note_idx", note_idx, 0);
    check("rst_mid_pending_events", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    apply_cyc = cyc;
    #1 mon_en = 1'b1;
    run_periods(p, seq, oseq, 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] seq [4];
    logic [1:0] oseq [5];
    logic [7:0] p, k;
    int n;

    #1;
    check("reset_speaker", speaker, 0);
    check("reset_active", active, 0);
    check("reset_note_idx", note_idx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    oseq = '{default: 2'd0};
    seq = '{8'h01, 8'h00, 8'h00, 8'h00};
    play(8'h01, seq, oseq, 2);

    seq = '{8'h80, 8'h80, 8'h00, 8'h00};
    play(8'h81, seq, oseq, 3);

    seq = '{8'h00, 8'h00, 8'h00, 8'h00};
    play(8'h04, seq, oseq, 1);

    oseq = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    seq  = '{8'h01, 8'h01, 8'h00, 8'h00};
    play(8'h01, seq, oseq, 3);

    reset_test(8'h24);

    for (int r = 0; r < 12; r++) begin
      p = 8'($urandom_range(255, 1));
      n = int'($urandom_range(4, 1));
      k = p;
      for (int s = 0; s < 4; s++) begin
        k = rand_keys(k);
        seq[s] = (s == n - 1) ? 8'h00 : k;
        if (s == n - 1) k = p;
      end
      for (int s = 0; s < 5; s++) oseq[s] = 2'($urandom_range(3, 0));
      play(p, seq, oseq, n);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("final_pending_events", exp_q.size(), 0);
    check("final_active", active, 0);
    check("final_speaker", speaker, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
